// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU types and constants for the hazard/stall control slice
package cpu_pkg;
  localparam int REG_W = 5;
  localparam int MUL_LAT_DEF = 4;
  localparam int DIV_LAT_DEF = 32;
  typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_t;
  // True when a stage writes a non-zero register equal to r
  function automatic logic reg_hit(input logic we, input logic [REG_W-1:0] wa, input logic [REG_W-1:0] r);
    return we && (wa != '0) && (wa == r);
  endfunction
endpackage

// File: rtl/md_sequencer.sv
// md_sequencer: busy-window sequencer for the multi-cycle mul/div unit
module md_sequencer import cpu_pkg::*; #(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      accept,
  input  logic      md_div,
  output md_state_t state,
  output logic      md_busy,
  output logic      md_done
);
  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  md_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // Next state: an accepted issue always (re)starts the busy window, otherwise count down
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    if (accept) begin
      state_d = MD_BUSY;
      cnt_d = md_div ? CW'(DIV_LAT - 1) : CW'(MUL_LAT - 1);
    end else if (state_q == MD_BUSY) begin
      state_d = (cnt_q == '0) ? MD_DONE : MD_BUSY;
      cnt_d = (cnt_q == '0) ? cnt_q : cnt_q - CW'(1);
    end else if (state_q == MD_DONE) begin
      state_d = MD_IDLE;
    end
  end
  // State and remaining-cycle register; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  assign state = state_q;
  assign md_busy = (state_q == MD_BUSY);
  assign md_done = (state_q == MD_DONE);
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: ID-stage stall/flush controller with mul/div sequencing and stall counter
module hazard_ctrl import cpu_pkg::*; #(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] rs_id,
  input  logic [REG_W-1:0] rt_id,
  input  logic             use_rs_id,
  input  logic             use_rt_id,
  input  logic             branch_id,
  input  logic             jreg_id,
  input  logic             md_start_id,
  input  logic             md_div_id,
  input  logic             md_read_id,
  input  logic             br_taken,
  input  logic [REG_W-1:0] rf_wa_ex,
  input  logic [REG_W-1:0] rf_wa_mem,
  input  logic             RegWrite_ex,
  input  logic             MemRead_ex,
  input  logic             RegWrite_mem,
  input  logic             MemRead_mem,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             md_busy,
  output logic             md_done,
  output logic [CNT_W-1:0] stall_cnt
);
  md_state_t md_state;
  logic ex_src, mem_src, ld_use, br_ld, jr_ld, md_haz, stall;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  assign ex_src = (use_rs_id && reg_hit(RegWrite_ex, rf_wa_ex, rs_id)) ||
                  (use_rt_id && reg_hit(RegWrite_ex, rf_wa_ex, rt_id));
  assign mem_src = (use_rs_id && reg_hit(RegWrite_mem, rf_wa_mem, rs_id)) ||
                   (use_rt_id && reg_hit(RegWrite_mem, rf_wa_mem, rt_id));
  assign ld_use = MemRead_ex && ex_src;
  assign br_ld = branch_id && ((MemRead_ex && ex_src) || (MemRead_mem && mem_src));
  assign jr_ld = jreg_id && MemRead_ex && reg_hit(RegWrite_ex, rf_wa_ex, rs_id);
  assign md_haz = (md_state == MD_BUSY) && (md_start_id || md_read_id);
  assign stall = ld_use || br_ld || jr_ld || md_haz;
  assign pc_en = !stall;
  assign ifid_en = !stall;
  assign idex_flush = stall;
  assign ifid_flush = !stall && br_taken;
  md_sequencer #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) u_md (
    .clk(clk),
    .rst_n(rst_n),
    .accept(md_start_id && !stall),
    .md_div(md_div_id),
    .state(md_state),
    .md_busy(md_busy),
    .md_done(md_done)
  );
  // Count every stalled cycle once, holding at all-ones
  always_comb stall_cnt_d = (stall && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
  // Stall counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else stall_cnt_q <= stall_cnt_d;
  end
  assign stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: vector table, directed sequences and random run against a cycle-indexed model
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] rs_id, rt_id, rf_wa_ex, rf_wa_mem;
  logic use_rs_id, use_rt_id, branch_id, jreg_id, md_start_id, md_div_id, md_read_id, br_taken;
  logic RegWrite_ex, MemRead_ex, RegWrite_mem, MemRead_mem;
  logic pc_en, ifid_en, ifid_flush, idex_flush, md_busy, md_done;
  logic [3:0] stall_cnt;
  int n_cmp = 0, n_err = 0;
  int cyc = 0, busy_lo = 0, busy_hi = -1, done_t = -1, scnt = 0;
  int obs_pc, obs_iff, obs_busy, obs_done;
  typedef struct {
    logic [4:0] rs, rt;
    logic urs, urt, br, jr, bt;
    logic [4:0] wex, wmem;
    logic rwex, mrex, rwmem, mrmem;
    logic e_stall, e_iff;
  } vec_t;
  vec_t tbl[14];

  hazard_ctrl #(.MUL_LAT(4), .DIV_LAT(32), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .rs_id(rs_id), .rt_id(rt_id),
    .use_rs_id(use_rs_id), .use_rt_id(use_rt_id), .branch_id(branch_id), .jreg_id(jreg_id),
    .md_start_id(md_start_id), .md_div_id(md_div_id), .md_read_id(md_read_id), .br_taken(br_taken),
    .rf_wa_ex(rf_wa_ex), .rf_wa_mem(rf_wa_mem), .RegWrite_ex(RegWrite_ex), .MemRead_ex(MemRead_ex),
    .RegWrite_mem(RegWrite_mem), .MemRead_mem(MemRead_mem), .pc_en(pc_en), .ifid_en(ifid_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .md_busy(md_busy), .md_done(md_done),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit hx(input logic [4:0] r);
    return RegWrite_ex && (rf_wa_ex != 5'd0) && (rf_wa_ex == r);
  endfunction

  function automatic bit hm(input logic [4:0] r);
    return RegWrite_mem && (rf_wa_mem != 5'd0) && (rf_wa_mem == r);
  endfunction

  function automatic int m_stall();
    bit exs, mems, busy;
    exs = (use_rs_id && hx(rs_id)) || (use_rt_id && hx(rt_id));
    mems = (use_rs_id && hm(rs_id)) || (use_rt_id && hm(rt_id));
    busy = (cyc >= busy_lo) && (cyc <= busy_hi);
    return ((MemRead_ex && exs) || (branch_id && ((MemRead_ex && exs) || (MemRead_mem && mems))) ||
            (jreg_id && MemRead_ex && hx(rs_id)) || (busy && (md_start_id || md_read_id))) ? 1 : 0;
  endfunction

  task automatic idle();
    rs_id = 5'd0; rt_id = 5'd0; rf_wa_ex = 5'd0; rf_wa_mem = 5'd0;
    use_rs_id = 1'b0; use_rt_id = 1'b0; branch_id = 1'b0; jreg_id = 1'b0;
    md_start_id = 1'b0; md_div_id = 1'b0; md_read_id = 1'b0; br_taken = 1'b0;
    RegWrite_ex = 1'b0; MemRead_ex = 1'b0; RegWrite_mem = 1'b0; MemRead_mem = 1'b0;
  endtask

  task automatic step();
    int st, mb, md;
    @(negedge clk);
    st = m_stall();
    mb = ((cyc >= busy_lo) && (cyc <= busy_hi)) ? 1 : 0;
    md = (cyc == done_t) ? 1 : 0;
    obs_pc = int'(pc_en); obs_iff = int'(ifid_flush);
    obs_busy = int'(md_busy); obs_done = int'(md_done);
    chk("pc_en", obs_pc, 1 - st);
    chk("ifid_en", int'(ifid_en), 1 - st);
    chk("idex_flush", int'(idex_flush), st);
    chk("ifid_flush", obs_iff, (st == 0 && br_taken) ? 1 : 0);
    chk("md_busy", obs_busy, mb);
    chk("md_done", obs_done, md);
    chk("stall_cnt", int'(stall_cnt), scnt);
    @(posedge clk);
    if (st == 1 && scnt < 15) scnt++;
    if (md_start_id && st == 0) begin
      busy_lo = cyc + 1;
      busy_hi = cyc + (md_div_id ? 32 : 4);
      done_t = busy_hi + 1;
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    #2;
    chk("rst_pc_en", int'(pc_en), 1);
    chk("rst_ifid_en", int'(ifid_en), 1);
    chk("rst_ifid_flush", int'(ifid_flush), 0);
    chk("rst_idex_flush", int'(idex_flush), 0);
    chk("rst_md_busy", int'(md_busy), 0);
    chk("rst_md_done", int'(md_done), 0);
    chk("rst_stall_cnt", int'(stall_cnt), 0);
    busy_lo = 0; busy_hi = -1; done_t = -1; scnt = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc++;
  endtask

  task automatic set_vec(input vec_t v);
    idle();
    rs_id = v.rs; rt_id = v.rt; use_rs_id = v.urs; use_rt_id = v.urt;
    branch_id = v.br; jreg_id = v.jr; br_taken = v.bt;
    rf_wa_ex = v.wex; rf_wa_mem = v.wmem;
    RegWrite_ex = v.rwex; MemRead_ex = v.mrex; RegWrite_mem = v.rwmem; MemRead_mem = v.mrmem;
  endtask

  initial begin
    int n, seen;
    idle();
    //          rs     rt     urs urt br jr bt wex    wmem   rwex mrex rwm mrm stall iff
    tbl[0]  = '{5'd8,  5'd0,  1, 0, 0, 0, 0, 5'd8,  5'd0,  1, 1, 0, 0, 1, 0};
    tbl[1]  = '{5'd8,  5'd0,  0, 0, 0, 0, 0, 5'd8,  5'd0,  1, 1, 0, 0, 0, 0};
    tbl[2]  = '{5'd1,  5'd9,  0, 1, 0, 0, 0, 5'd9,  5'd0,  1, 1, 0, 0, 1, 0};
    tbl[3]  = '{5'd0,  5'd0,  1, 0, 0, 0, 0, 5'd0,  5'd0,  1, 1, 0, 0, 0, 0};
    tbl[4]  = '{5'd8,  5'd0,  1, 0, 0, 0, 0, 5'd8,  5'd0,  1, 0, 0, 0, 0, 0};
    tbl[5]  = '{5'd8,  5'd0,  1, 0, 1, 0, 0, 5'd0,  5'd8,  0, 0, 1, 1, 1, 0};
    tbl[6]  = '{5'd8,  5'd0,  1, 0, 0, 0, 0, 5'd0,  5'd8,  0, 0, 1, 1, 0, 0};
    tbl[7]  = '{5'd8,  5'd0,  1, 0, 1, 0, 1, 5'd8,  5'd0,  1, 0, 0, 0, 0, 1};
    tbl[8]  = '{5'd31, 5'd0,  1, 0, 0, 1, 0, 5'd31, 5'd0,  1, 0, 0, 0, 0, 0};
    tbl[9]  = '{5'd31, 5'd0,  1, 0, 0, 1, 0, 5'd31, 5'd0,  1, 1, 0, 0, 1, 0};
    tbl[10] = '{5'd8,  5'd0,  1, 0, 0, 0, 0, 5'd8,  5'd0,  0, 1, 0, 0, 0, 0};
    tbl[11] = '{5'd8,  5'd0,  1, 0, 0, 0, 1, 5'd8,  5'd0,  1, 1, 0, 0, 1, 0};
    tbl[12] = '{5'd3,  5'd12, 0, 1, 1, 0, 0, 5'd0,  5'd12, 0, 0, 1, 1, 1, 0};
    tbl[13] = '{5'd5,  5'd0,  1, 0, 1, 0, 0, 5'd0,  5'd5,  0, 0, 1, 0, 0, 0};
    do_reset();
    for (int i = 0; i < 14; i++) begin
      set_vec(tbl[i]);
      step();
      chk($sformatf("tbl%0d_pc_en", i), obs_pc, tbl[i].e_stall ? 0 : 1);
      chk($sformatf("tbl%0d_ifid_flush", i), obs_iff, int'(tbl[i].e_iff));
    end
    // load-use: one bubble, then the load has moved on
    do_reset();
    rs_id = 5'd8; use_rs_id = 1'b1; rf_wa_ex = 5'd8; RegWrite_ex = 1'b1; MemRead_ex = 1'b1;
    step();
    chk("lu_pc_en", obs_pc, 0);
    idle(); rs_id = 5'd8; use_rs_id = 1'b1; rf_wa_mem = 5'd8; RegWrite_mem = 1'b1; MemRead_mem = 1'b1;
    step();
    chk("lu_released", obs_pc, 1);
    chk("lu_stall_cnt", int'(stall_cnt), 1);
    // beq behind a load: EX then MEM match, then the branch resolves
    do_reset();
    rs_id = 5'd8; use_rs_id = 1'b1; branch_id = 1'b1;
    rf_wa_ex = 5'd8; RegWrite_ex = 1'b1; MemRead_ex = 1'b1;
    step();
    chk("beq_ex_stall", obs_pc, 0);
    rf_wa_ex = 5'd0; RegWrite_ex = 1'b0; MemRead_ex = 1'b0;
    rf_wa_mem = 5'd8; RegWrite_mem = 1'b1; MemRead_mem = 1'b1;
    step();
    chk("beq_mem_stall", obs_pc, 0);
    rf_wa_mem = 5'd0; RegWrite_mem = 1'b0; MemRead_mem = 1'b0; br_taken = 1'b1;
    step();
    chk("beq_go", obs_pc, 1);
    chk("beq_flush", obs_iff, 1);
    idle();
    step();
    chk("beq_flush_end", obs_iff, 0);
    chk("beq_stall_cnt", int'(stall_cnt), 2);
    // jr after ALU op vs after load
    jreg_id = 1'b1; rs_id = 5'd31; use_rs_id = 1'b1; rf_wa_ex = 5'd31; RegWrite_ex = 1'b1;
    step();
    chk("jr_alu", obs_pc, 1);
    MemRead_ex = 1'b1;
    step();
    chk("jr_load", obs_pc, 0);
    MemRead_ex = 1'b0; RegWrite_ex = 1'b0;
    step();
    chk("jr_load_release", obs_pc, 1);
    // mult then mflo while busy
    do_reset();
    md_start_id = 1'b1;
    step();
    chk("mul_issue", obs_pc, 1);
    md_start_id = 1'b0;
    step();
    chk("mul_busy_t1", obs_busy, 1);
    md_read_id = 1'b1;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (obs_pc == 1) break;
      n++;
    end
    chk("mflo_stalls", n, 3);
    chk("mflo_release_done", obs_done, 1);
    md_read_id = 1'b0;
    step();
    chk("mul_idle", obs_busy + obs_done, 0);
    // div, then another div issued in the done cycle
    do_reset();
    md_start_id = 1'b1; md_div_id = 1'b1;
    step();
    md_start_id = 1'b0;
    n = 0;
    repeat (32) begin
      step();
      n += obs_busy;
    end
    chk("div1_busy", n, 32);
    md_start_id = 1'b1;
    step();
    chk("div1_done", obs_done, 1);
    chk("div2_accept", obs_pc, 1);
    md_start_id = 1'b0;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (obs_busy == 0) break;
      n++;
    end
    chk("div2_busy", n, 32);
    chk("div2_done", obs_done, 1);
    // reset mid-busy aborts with no done
    md_start_id = 1'b1;
    step();
    md_start_id = 1'b0; md_div_id = 1'b0;
    repeat (5) step();
    chk("abort_pre_busy", obs_busy, 1);
    do_reset();
    seen = 0;
    repeat (40) begin
      step();
      seen += obs_done + obs_busy;
    end
    chk("abort_no_done", seen, 0);
    // random traffic against the model
    for (int k = 0; k < 600; k++) begin
      rs_id = 5'($urandom_range(0, 3)); rt_id = 5'($urandom_range(0, 3));
      rf_wa_ex = 5'($urandom_range(0, 3)); rf_wa_mem = 5'($urandom_range(0, 3));
      use_rs_id = 1'($urandom_range(0, 1)); use_rt_id = 1'($urandom_range(0, 1));
      branch_id = ($urandom_range(0, 3) == 0); jreg_id = ($urandom_range(0, 5) == 0);
      br_taken = 1'($urandom_range(0, 1));
      RegWrite_ex = 1'($urandom_range(0, 1)); MemRead_ex = ($urandom_range(0, 2) == 0);
      RegWrite_mem = 1'($urandom_range(0, 1)); MemRead_mem = ($urandom_range(0, 2) == 0);
      md_start_id = ($urandom_range(0, 7) == 0); md_div_id = ($urandom_range(0, 3) == 0);
      md_read_id = ($urandom_range(0, 4) == 0);
      step();
    end
    // counter saturation
    do_reset();
    rs_id = 5'd8; use_rs_id = 1'b1; rf_wa_ex = 5'd8; RegWrite_ex = 1'b1; MemRead_ex = 1'b1;
    repeat (16) step();
    chk("sat_16", int'(stall_cnt), 15);
    repeat (5) step();
    chk("sat_hold", int'(stall_cnt), 15);
    idle();
    step();
    chk("sat_idle", int'(stall_cnt), 15);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline stall/flush controller for the 5-stage CPU, sitting beside the forwarding unit in the ID stage. It detects hazards that forwarding cannot cover: load-use, branch or jr after a load, and accesses to the multi-cycle mul/div unit while it is busy. It drives the PC, IF/ID and ID/EX enables and flushes. It also sequences the mul/div unit's busy window and keeps a saturating stall-cycle counter for performance measurement.

## Interface
Parameters:
- MUL_LAT, 4, mul busy cycles (>=1)
- DIV_LAT, 32, div busy cycles (>=1)
- CNT_W, 32, stall counter width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- rs_id, rt_id  in  5  source register numbers of the instruction in ID
- use_rs_id, use_rt_id  in  1  the ID instruction actually reads rs / rt
- branch_id  in  1  beq/bne in ID (compare resolved in ID)
- jreg_id  in  1  jr/jalr in ID
- md_start_id  in  1  mult/div in ID
- md_div_id  in  1  the mul/div op is a divide
- md_read_id  in  1  mfhi/mflo in ID
- br_taken  in  1  branch/jump redirect resolved in ID this cycle
- rf_wa_ex, rf_wa_mem  in  5  destination register numbers in EX / MEM
- RegWrite_ex, MemRead_ex  in  1  EX-stage control bits
- RegWrite_mem, MemRead_mem  in  1  MEM-stage control bits
- pc_en  out  1  PC write enable
- ifid_en  out  1  IF/ID register enable
- ifid_flush  out  1  clear IF/ID (bubble)
- idex_flush  out  1  insert a bubble into ID/EX
- md_busy  out  1  mul/div in progress
- md_done  out  1  HI/LO write strobe, one cycle
- stall_cnt  out  CNT_W  cycles with pc_en=0, saturating

## Operation
Match terms:
- ex_hit(r): RegWrite_ex && rf_wa_ex!=0 && rf_wa_ex==r
- mem_hit(r): the same on the MEM fields
- A source r counts only when its use_* bit is set.

Stall causes (combinational, OR-ed together into `stall`):
- Load-use: MemRead_ex && ex_hit on any used source.
- Branch after load: branch_id && ((MemRead_ex && ex_hit) || (MemRead_mem && mem_hit)) on rs/rt. This gives 2 bubbles behind a load in EX and 1 behind a load in MEM.
- jr after load: jreg_id && MemRead_ex && ex_hit(rs_id). One bubble; the jump target is then forwarded from dm_rd.
- Branch after ALU op in EX: no stall; forwarding covers it.
- Mul/div hazard: state==MD_BUSY && (md_start_id || md_read_id).

Outputs:
- stall=1: pc_en=0, ifid_en=0, idex_flush=1, ifid_flush=0.
- stall=0: pc_en=1, ifid_en=1, idex_flush=0, ifid_flush=br_taken. br_taken is ignored while stalled; the branch re-resolves once the stall clears.

Mul/div FSM (states MD_IDLE, MD_BUSY, MD_DONE):
- An issue is accepted when md_start_id && !stall.
- On accept, load md_cnt with LAT-1 (LAT = md_div_id ? DIV_LAT : MUL_LAT) and go to MD_BUSY.
- MD_BUSY: decrement md_cnt each cycle; when md_cnt==0, go to MD_DONE.
- MD_DONE: md_done=1 for one cycle, then MD_IDLE. An accept during MD_DONE goes straight to MD_BUSY.
- md_busy = (state==MD_BUSY).
- md_cnt is wide enough for max(MUL_LAT, DIV_LAT)-1.

stall_cnt increments each cycle with pc_en=0 and holds at all-ones.

## Timing
- Reset (asynchronous assert, synchronous release): state=MD_IDLE, md_cnt=0, stall_cnt=0, md_busy=0, md_done=0. While reset is asserted with inputs idle, pc_en=1, ifid_en=1 and both flushes are 0.
- Reset during MD_BUSY aborts the operation with no md_done.
- pc_en, ifid_en, ifid_flush and idex_flush are combinational, same cycle as their inputs.
- md_busy, md_done and stall_cnt are registered.
- Mul/div issue accepted in cycle t: md_busy=1 in cycles t+1..t+LAT, md_done=1 in t+LAT+1.
- An mfhi/mflo in ID during MD_DONE does not stall.
- Simultaneous load-use and mul/div stall produce a single stall; stall_cnt counts that cycle once.

## Structure
- Shared package cpu_pkg holds:
  - the md_state_t enum (MD_IDLE, MD_BUSY, MD_DONE)
  - REG_W=5
  - the default MUL_LAT/DIV_LAT constants
- One sub-module, md_sequencer, holds the FSM and md_cnt. Its inputs are accept and md_div; its outputs are state, md_busy and md_done.
- Hazard detection and the stall counter live in the top level.

## Test plan
- lw $t0 in EX (rf_wa_ex=8, MemRead_ex=1, RegWrite_ex=1), add reading rs_id=8 in ID -> one cycle of pc_en=0, idex_flush=1; stall_cnt=1.
- beq rs_id=8 with the load to $8 in EX -> 2 stall cycles (EX then MEM match), then br_taken=1 -> ifid_flush=1 for one cycle.
- jr rs_id=31 with an ALU op writing $31 in EX -> no stall. With a load writing $31 in EX -> exactly 1 stall.
- mult accepted at t with MUL_LAT=4 -> md_busy in t+1..t+4, md_done at t+5. mflo in ID at t+2 -> stall through t+4, released at t+5.
- Back-to-back div issue during MD_DONE (DIV_LAT=32) -> md_busy for 32 cycles with no MD_IDLE gap. rst_n pulsed low mid-busy -> md_busy=0 immediately and md_done never asserted.
- Force 2^CNT_W stall cycles (CNT_W=4) -> stall_cnt saturates at 15 and holds.
